// File: rtl/wb_ram_arbiter.sv
// Two-master to one-slave Wishbone arbiter for a shared RAM. Grants are round-robin
// and held for the whole cycle. A forced idle cycle between owners restarts any burst.
module wb_ram_arbiter #(
   parameter int aw = 32,
   parameter int dw = 32
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic [aw-1:0] m0_adr_i,
   input  logic [dw-1:0] m0_dat_i,
   input  logic [3:0]    m0_sel_i,
   input  logic          m0_we_i,
   input  logic [2:0]    m0_cti_i,
   input  logic [1:0]    m0_bte_i,
   input  logic          m0_cyc_i,
   input  logic          m0_stb_i,
   output logic [dw-1:0] m0_dat_o,
   output logic          m0_ack_o,
   output logic          m0_err_o,
   input  logic [aw-1:0] m1_adr_i,
   input  logic [dw-1:0] m1_dat_i,
   input  logic [3:0]    m1_sel_i,
   input  logic          m1_we_i,
   input  logic [2:0]    m1_cti_i,
   input  logic [1:0]    m1_bte_i,
   input  logic          m1_cyc_i,
   input  logic          m1_stb_i,
   output logic [dw-1:0] m1_dat_o,
   output logic          m1_ack_o,
   output logic          m1_err_o,
   output logic [aw-1:0] s_adr_o,
   output logic [dw-1:0] s_dat_o,
   output logic [3:0]    s_sel_o,
   output logic          s_we_o,
   output logic [2:0]    s_cti_o,
   output logic [1:0]    s_bte_o,
   output logic          s_cyc_o,
   output logic          s_stb_o,
   input  logic [dw-1:0] s_dat_i,
   input  logic          s_ack_i,
   input  logic          s_err_i,
   output logic [1:0]    gnt_o
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   state_t state_q, state_d;
   logic   last_owner_q, last_owner_d;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      case (state_q)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_d      = last_owner_q ? GRANT0 : GRANT1;
               last_owner_d = ~last_owner_q;
            end else if (m0_cyc_i) begin
               state_d      = GRANT0;
               last_owner_d = 1'b0;
            end else if (m1_cyc_i) begin
               state_d      = GRANT1;
               last_owner_d = 1'b1;
            end
         end
         // Release always passes through IDLE, never straight to the other owner.
         GRANT0:  if (!m0_cyc_i) state_d = IDLE;
         GRANT1:  if (!m1_cyc_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      s_we_o   = 1'b0;
      s_cti_o  = '0;
      s_bte_o  = '0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      gnt_o    = 2'b00;
      case (state_q)
         GRANT0: begin
            gnt_o    = 2'b01;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i & m0_cyc_i;
            s_cti_o  = m0_cti_i;
            s_bte_o  = m0_bte_i;
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i & m0_cyc_i;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i;
         end
         GRANT1: begin
            gnt_o    = 2'b10;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i & m1_cyc_i;
            s_cti_o  = m1_cti_i;
            s_bte_o  = m1_bte_i;
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i & m1_cyc_i;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i;
         end
         default: ;
      endcase
   end

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Scoreboard bench for wb_ram_arbiter: stimulus queues expected beats, a monitor
// pops them on every acked slave beat and also logs grant order and idle gaps.
module tb_wb_ram_arbiter;

   logic        clk;
   logic        rst;
   logic [31:0] madr[2];
   logic [31:0] mdw[2];
   logic [3:0]  msel[2];
   logic        mwe[2];
   logic [2:0]  mcti[2];
   logic [1:0]  mbte[2];
   logic        mcyc[2];
   logic        mstb[2];
   logic [31:0] mdr[2];
   logic        mack[2];
   logic        merr[2];
   logic [31:0] s_adr_o, s_dat_o, s_dat_i;
   logic [3:0]  s_sel_o;
   logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
   logic [2:0]  s_cti_o;
   logic [1:0]  s_bte_o;
   logic [1:0]  gnt_o;

   logic        slave_en, force_ack, force_err, force_dat_en;
   logic [31:0] force_dat;

   typedef struct {
      int          owner;
      logic [31:0] adr;
      logic [2:0]  cti;
   } exp_t;

   exp_t sb[$];
   int   g_owner[$];
   int   g_idle[$];
   int   checks = 0;
   int   errors = 0;

   wb_ram_arbiter #(.aw(32), .dw(32)) dut (
      .wb_clk_i(clk),       .wb_rst_i(rst),
      .m0_adr_i(madr[0]),   .m0_dat_i(mdw[0]),   .m0_sel_i(msel[0]), .m0_we_i(mwe[0]),
      .m0_cti_i(mcti[0]),   .m0_bte_i(mbte[0]),  .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]),
      .m0_dat_o(mdr[0]),    .m0_ack_o(mack[0]),  .m0_err_o(merr[0]),
      .m1_adr_i(madr[1]),   .m1_dat_i(mdw[1]),   .m1_sel_i(msel[1]), .m1_we_i(mwe[1]),
      .m1_cti_i(mcti[1]),   .m1_bte_i(mbte[1]),  .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]),
      .m1_dat_o(mdr[1]),    .m1_ack_o(mack[1]),  .m1_err_o(merr[1]),
      .s_adr_o(s_adr_o),    .s_dat_o(s_dat_o),   .s_sel_o(s_sel_o),  .s_we_o(s_we_o),
      .s_cti_o(s_cti_o),    .s_bte_o(s_bte_o),   .s_cyc_o(s_cyc_o),  .s_stb_o(s_stb_o),
      .s_dat_i(s_dat_i),    .s_ack_i(s_ack_i),   .s_err_i(s_err_i),
      .gnt_o(gnt_o)
   );

   // Zero-wait slave: read data is the inverted address so the owner is identifiable.
   assign s_ack_i = (slave_en & s_cyc_o & s_stb_o) | force_ack;
   assign s_err_i = force_err;
   assign s_dat_i = force_dat_en ? force_dat : ~s_adr_o;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int m, input logic [31:0] adr, input int beats, input bit burst);
      for (int b = 0; b < beats; b++) begin
         exp_t e;
         e.owner = m;
         e.adr   = adr + 32'(4 * b);
         e.cti   = burst ? ((b == beats - 1) ? 3'b111 : 3'b010) : 3'b000;
         sb.push_back(e);
      end
   endtask

   task automatic run(input int m, input logic [31:0] adr, input int beats, input bit burst);
      int n;
      @(posedge clk); #1;
      mcyc[m] = 1'b1;
      mstb[m] = 1'b1;
      mwe[m]  = 1'b0;
      msel[m] = 4'hf;
      mbte[m] = 2'b00;
      for (int b = 0; b < beats; b++) begin
         madr[m] = adr + 32'(4 * b);
         mdw[m]  = madr[m] ^ 32'h5a5a5a5a;
         mcti[m] = burst ? ((b == beats - 1) ? 3'b111 : 3'b010) : 3'b000;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!mack[m] && n < 200);
         if (!mack[m]) check("ack_timeout", 32'(m), 32'hffffffff);
         @(posedge clk); #1;
      end
      mcyc[m] = 1'b0;
      mstb[m] = 1'b0;
      madr[m] = '0;
      mcti[m] = '0;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_grants(input string name, input int base, input int n, input int first);
      check({name, "_count"}, 32'(g_owner.size() - base), 32'(n));
      for (int i = 0; i < n && base + i < g_owner.size(); i++) begin
         check({name, "_owner"}, 32'(g_owner[base + i]), 32'((first + i) % 2));
         if (i > 0) check({name, "_idle"}, 32'(g_idle[base + i]), 32'd1);
      end
   endtask

   // Monitor: pops one expectation per accepted slave beat, logs each new grant.
   initial begin
      logic [1:0] prev;
      int         idle_cnt;
      exp_t       e;
      int         o;
      prev     = 2'b00;
      idle_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev     = 2'b00;
            idle_cnt = 0;
         end else begin
            if (s_cyc_o && s_stb_o && s_ack_i) begin
               if (sb.size() == 0) check("unexpected_beat", s_adr_o, 32'hffffffff);
               else begin
                  e = sb.pop_front();
                  o = e.owner;
                  check("beat_gnt", 32'(gnt_o), 32'(1 << o));
                  check("beat_adr", s_adr_o, e.adr);
                  check("beat_cti", 32'(s_cti_o), 32'(e.cti));
                  check("owner_ack", 32'(mack[o]), 32'd1);
                  check("other_ack", 32'(mack[1-o]), 32'd0);
                  check("owner_dat", mdr[o], ~e.adr);
                  check("other_dat", mdr[1-o], ~e.adr);
               end
            end
            if (gnt_o != 2'b00 && prev != 2'b00 && gnt_o != prev)
               check("direct_handover", 32'(gnt_o), 32'(prev));
            if (gnt_o == 2'b00) idle_cnt++;
            else if (gnt_o != prev) begin
               g_owner.push_back(gnt_o[1] ? 1 : 0);
               g_idle.push_back(idle_cnt);
               idle_cnt = 0;
            end
            prev = gnt_o;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int n;
      rst = 1'b1;
      slave_en = 1'b1; force_ack = 1'b0; force_err = 1'b0;
      force_dat_en = 1'b0; force_dat = '0;
      for (int m = 0; m < 2; m++) begin
         madr[m] = '0; mdw[m] = '0; msel[m] = '0; mwe[m] = 1'b0;
         mcti[m] = '0; mbte[m] = '0; mcyc[m] = 1'b0; mstb[m] = 1'b0;
      end
      repeat (3) @(negedge clk);
      check("rst_gnt", 32'(gnt_o), 32'd0);
      check("rst_cyc", 32'(s_cyc_o), 32'd0);
      check("rst_stb", 32'(s_stb_o), 32'd0);
      check("rst_we", 32'(s_we_o), 32'd0);
      check("rst_acks", 32'({mack[0], mack[1], merr[0], merr[1]}), 32'd0);
      check("rst_adr", s_adr_o, 32'd0);
      rst = 1'b0;

      // Single master read: one-cycle registered grant latency.
      base = g_owner.size();
      push(0, 32'h10, 1, 0);
      fork
         run(0, 32'h10, 1, 0);
         begin
            @(posedge clk);
            @(negedge clk);
            check("lat_gnt_idle", 32'(gnt_o), 32'd0);
            check("lat_cyc_idle", 32'(s_cyc_o), 32'd0);
            @(negedge clk);
            check("lat_gnt", 32'(gnt_o), 32'd1);
            check("lat_adr", s_adr_o, 32'h10);
         end
      join
      check_grants("single", base, 1, 0);

      // Simultaneous requests after reset: m0 first, then m1 after one idle cycle.
      reset_dut();
      base = g_owner.size();
      push(0, 32'h100, 1, 0);
      push(1, 32'h200, 1, 0);
      fork
         run(0, 32'h100, 1, 0);
         run(1, 32'h200, 1, 0);
      join
      check_grants("contend", base, 2, 0);

      // m1 burst with m0 arriving mid-burst.
      base = g_owner.size();
      push(1, 32'h20, 4, 1);
      push(0, 32'h30, 1, 0);
      fork
         run(1, 32'h20, 4, 1);
         begin
            repeat (3) @(posedge clk);
            run(0, 32'h30, 1, 0);
         end
      join
      check_grants("burst", base, 2, 1);

      // Alternating contention, six grants.
      reset_dut();
      base = g_owner.size();
      for (int i = 0; i < 3; i++) begin
         push(0, 32'h400 + 32'(16 * i), 1, 0);
         push(1, 32'h500 + 32'(16 * i), 1, 0);
      end
      fork
         for (int i = 0; i < 3; i++) run(0, 32'h400 + 32'(16 * i), 1, 0);
         for (int j = 0; j < 3; j++) run(1, 32'h500 + 32'(16 * j), 1, 0);
      join
      check_grants("alt", base, 6, 0);

      // Asynchronous reset mid-burst while m0 owns the slave.
      slave_en = 1'b0;
      @(posedge clk); #1;
      mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 32'h60; mcti[0] = 3'b010; msel[0] = 4'hf;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (gnt_o != 2'b01 && n < 20);
      check("pre_rst_gnt", 32'(gnt_o), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_cyc", 32'(s_cyc_o), 32'd0);
      check("async_rst_stb", 32'(s_stb_o), 32'd0);
      check("async_rst_gnt", 32'(gnt_o), 32'd0);
      mcyc[0] = 1'b0; mstb[0] = 1'b0; madr[0] = '0; mcti[0] = '0;
      slave_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      base = g_owner.size();
      push(0, 32'h70, 1, 0);
      push(1, 32'h80, 1, 0);
      fork
         run(0, 32'h70, 1, 0);
         run(1, 32'h80, 1, 0);
      join
      check_grants("post_rst", base, 2, 0);

      // Stray slave response while idle.
      repeat (2) @(negedge clk);
      force_ack = 1'b1; force_err = 1'b1;
      force_dat_en = 1'b1; force_dat = 32'hDEADBEEF;
      @(negedge clk);
      check("stray_gnt", 32'(gnt_o), 32'd0);
      check("stray_ack", 32'({mack[0], mack[1]}), 32'd0);
      check("stray_err", 32'({merr[0], merr[1]}), 32'd0);
      check("stray_dat0", mdr[0], 32'hDEADBEEF);
      check("stray_dat1", mdr[1], 32'hDEADBEEF);
      force_ack = 1'b0; force_err = 1'b0; force_dat_en = 1'b0;

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
